// File: rtl/mem_native_arbiter_if.sv
// PicoRV32 native memory bus: a single requester-to-memory link.
// The master drives the request; the slave returns ready/rdata.
interface mem_native_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_native_arbiter.sv
// Round-robin arbiter sharing one native memory port between a trusted CPU (s0)
// and an untrusted requester (s1); s1 accesses to a protected window fault locally.
module mem_native_arbiter #(
  parameter logic [31:0] PROT_BASE  = 32'h0000_0000,
  parameter logic [31:0] PROT_END   = 32'h0000_0000,
  parameter logic [31:0] FAULT_DATA = 32'hDEAD_BEEF
) (
  input  logic                        clk,
  input  logic                        reset,
  mem_native_arbiter_if.slave         s0,
  mem_native_arbiter_if.slave         s1,
  mem_native_arbiter_if.master        m,
  output logic                        fault_valid,
  output logic [31:0]                 fault_addr,
  output logic                        fault_write,
  input  logic                        fault_clr
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FAULT1} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        fault_valid_q, fault_valid_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        fault_write_q, fault_write_d;
  logic        s1_in_win;

  // An inverted or zero-length window (PROT_END <= PROT_BASE) never matches.
  assign s1_in_win = (PROT_END > PROT_BASE) && (s1.addr >= PROT_BASE) && (s1.addr < PROT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_write_q <= fault_write_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_write_d = fault_write_q;
    case (state_q)
      IDLE: begin
        if (s0.valid && (!s1.valid || last_grant_q)) state_d = GRANT0;
        else if (s1.valid)                            state_d = s1_in_win ? FAULT1 : GRANT1;
      end
      GRANT0: begin
        if (m.ready) begin
          last_grant_d = 1'b0;
          state_d      = IDLE;
        end else if (!s0.valid) begin
          state_d = IDLE;
        end
      end
      GRANT1: begin
        if (m.ready) begin
          last_grant_d = 1'b1;
          state_d      = IDLE;
        end else if (!s1.valid) begin
          state_d = IDLE;
        end
      end
      FAULT1: begin
        last_grant_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // First fault wins; a capture overrides a simultaneous clear.
    if (state_q == FAULT1 && !fault_valid_q) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = s1.addr;
      fault_write_d = |s1.wstrb;
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
    end
  end

  always_comb begin
    m.valid  = 1'b0;
    m.instr  = 1'b0;
    m.addr   = '0;
    m.wdata  = '0;
    m.wstrb  = '0;
    s0.ready = 1'b0;
    s0.rdata = '0;
    s1.ready = 1'b0;
    s1.rdata = '0;
    case (state_q)
      GRANT0: begin
        m.valid  = s0.valid;
        m.instr  = s0.instr;
        m.addr   = s0.addr;
        m.wdata  = s0.wdata;
        m.wstrb  = s0.wstrb;
        s0.ready = m.ready;
        s0.rdata = m.ready ? m.rdata : '0;
      end
      GRANT1: begin
        m.valid  = s1.valid;
        m.instr  = s1.instr;
        m.addr   = s1.addr;
        m.wdata  = s1.wdata;
        m.wstrb  = s1.wstrb;
        s1.ready = m.ready;
        s1.rdata = m.ready ? m.rdata : '0;
      end
      FAULT1: begin
        s1.ready = 1'b1;
        s1.rdata = FAULT_DATA;
      end
      default: ;
    endcase
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_write = fault_write_q;

endmodule

// File: tb/tb_mem_native_arbiter.sv
// Self-checking bench for mem_native_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_mem_native_arbiter;

  localparam logic [31:0] PB = 32'h0000_8000;
  localparam logic [31:0] PE = 32'h0000_9000;
  localparam logic [31:0] FD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fault_clr = 1'b0;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        fault_write;

  mem_native_arbiter_if s0_bus();
  mem_native_arbiter_if s1_bus();
  mem_native_arbiter_if m_bus();

  mem_native_arbiter #(.PROT_BASE(PB), .PROT_END(PE), .FAULT_DATA(FD)) dut (
    .clk(clk), .reset(reset), .s0(s0_bus), .s1(s1_bus), .m(m_bus),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_write(fault_write),
    .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who the bus currently serves (-1 nobody, 0/1 port, 2 local fault).
  int          srv = -1;
  int          last = 1;
  logic        mfv = 1'b0;
  logic [31:0] mfa = '0;
  logic        mfw = 1'b0;
  logic [31:0] grant_q[$];

  function automatic bit in_win(input logic [31:0] a);
    return (a >= PB) && (a < PE);
  endfunction

  always @(negedge clk) begin
    logic        e_mv, e_ins, e_r0, e_r1;
    logic [31:0] e_a, e_wd, e_d0, e_d1;
    logic [3:0]  e_st;
    int          pick;
    e_mv = 0; e_ins = 0; e_a = '0; e_wd = '0; e_st = '0;
    e_r0 = 0; e_d0 = '0; e_r1 = 0; e_d1 = '0;
    if (srv == 0) begin
      e_mv = s0_bus.valid; e_ins = s0_bus.instr; e_a = s0_bus.addr;
      e_wd = s0_bus.wdata; e_st = s0_bus.wstrb;
      e_r0 = m_bus.ready;  e_d0 = m_bus.ready ? m_bus.rdata : '0;
    end else if (srv == 1) begin
      e_mv = s1_bus.valid; e_ins = s1_bus.instr; e_a = s1_bus.addr;
      e_wd = s1_bus.wdata; e_st = s1_bus.wstrb;
      e_r1 = m_bus.ready;  e_d1 = m_bus.ready ? m_bus.rdata : '0;
    end else if (srv == 2) begin
      e_r1 = 1'b1; e_d1 = FD;
    end
    chk("m_valid", m_bus.valid, e_mv);
    chk("m_instr", m_bus.instr, e_ins);
    chk("m_addr",  m_bus.addr,  e_a);
    chk("m_wdata", m_bus.wdata, e_wd);
    chk("m_wstrb", m_bus.wstrb, e_st);
    chk("s0_ready", s0_bus.ready, e_r0);
    chk("s0_rdata", s0_bus.rdata, e_d0);
    chk("s1_ready", s1_bus.ready, e_r1);
    chk("s1_rdata", s1_bus.rdata, e_d1);
    chk("fault_valid", fault_valid, mfv);
    chk("fault_addr",  fault_addr,  mfa);
    chk("fault_write", fault_write, mfw);
    if (m_bus.valid && m_bus.ready) grant_q.push_back(m_bus.addr);

    if (reset) begin
      srv = -1; last = 1; mfv = 0; mfa = '0; mfw = 0;
    end else begin
      if (srv == 2 && !mfv) begin
        mfv = 1; mfa = s1_bus.addr; mfw = |s1_bus.wstrb;
      end else if (fault_clr) begin
        mfv = 0;
      end
      if (srv == 2) begin
        last = 1; srv = -1;
      end else if (srv == 0 || srv == 1) begin
        if (m_bus.ready) begin
          last = srv; srv = -1;
        end else if (!(srv == 0 ? s0_bus.valid : s1_bus.valid)) begin
          srv = -1;
        end
      end else begin
        pick = -1;
        if (s0_bus.valid && s1_bus.valid) pick = 1 - last;
        else if (s0_bus.valid)            pick = 0;
        else if (s1_bus.valid)            pick = 1;
        if (pick == 1 && in_win(s1_bus.addr)) srv = 2;
        else                                  srv = pick;
      end
    end
  end

  // Downstream responder: fixed latency when fix_lat >= 0, else random 0..3 cycles.
  int          fix_lat = 1;
  logic [31:0] fix_rd = 32'h1234_5678;
  initial begin
    bit busy = 0;
    int lat = 0;
    m_bus.ready = 1'b0;
    m_bus.rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (m_bus.ready) begin
        m_bus.ready = 1'b0; m_bus.rdata = '0; busy = 0;
      end else if (!m_bus.valid) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        end
        if (lat == 0) begin
          m_bus.ready = 1'b1;
          m_bus.rdata = (fix_lat >= 0) ? fix_rd : $urandom;
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic set_port(input int p, input logic v, input logic [31:0] a,
                          input logic [3:0] st, input logic [31:0] wd, input logic ins);
    if (p == 0) begin
      s0_bus.valid = v; s0_bus.addr = a; s0_bus.wstrb = st; s0_bus.wdata = wd; s0_bus.instr = ins;
    end else begin
      s1_bus.valid = v; s1_bus.addr = a; s1_bus.wstrb = st; s1_bus.wdata = wd; s1_bus.instr = ins;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after dropping valid.
  task automatic do_req(input int p, input logic [31:0] a, input logic [3:0] st,
                        input logic [31:0] wd, input logic ins,
                        output int ncyc, output logic [31:0] rd, output int first_mv);
    ncyc = 0; rd = '0; first_mv = 0;
    set_port(p, 1'b1, a, st, wd, ins);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (m_bus.valid && first_mv == 0) first_mv = n;
      if ((p == 0) ? s0_bus.ready : s1_bus.ready) begin
        rd = (p == 0) ? s0_bus.rdata : s1_bus.rdata;
        ncyc = n;
        break;
      end
    end
    if (ncyc == 0) begin
      checks++; errors++;
      $display("FAIL req_timeout port %0d addr %h got no ready want ready within 60 cycles", p, a);
    end
    @(posedge clk); #1;
    set_port(p, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n_req);
    int          nc, fm, r;
    logic [31:0] rd, a;
    for (int i = 0; i < n_req; i++) begin
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      r = $urandom_range(0, 3);
      if (r == 0)      a = PB + 32'($urandom_range(0, 1023) * 4);
      else if (r == 1) a = ($urandom_range(0, 1) == 1) ? PE : PB - 32'd4;
      else             a = $urandom & 32'hFFFF_FFFC;
      do_req(p, a, 4'($urandom_range(0, 1) ? $urandom_range(0, 15) : 0), $urandom,
             1'($urandom_range(0, 1)), nc, rd, fm);
    end
  endtask

  bit rand_on = 0;

  initial begin
    int          nc, fm, nc1, fm1;
    logic [31:0] rd, rd1;
    set_port(0, 1'b0, '0, '0, '0, 1'b0);
    set_port(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("reset_m_valid", m_bus.valid, 0);
    chk("reset_fault_valid", fault_valid, 0);
    chk("reset_fault_addr", fault_addr, 0);
    chk("reset_s1_rdata", s1_bus.rdata, 0);
    @(posedge clk); #1;

    // Single read: m_valid on the 2nd cycle, ready on the 3rd.
    fix_lat = 1; fix_rd = 32'h1234_5678;
    do_req(0, 32'h100, 4'h0, '0, 1'b0, nc, rd, fm);
    chk("single_first_mvalid", fm, 2);
    chk("single_ready_cycle", nc, 3);
    chk("single_rdata", rd, 32'h1234_5678);

    // Contention from reset: strict alternation starting with port 0.
    apply_reset();
    grant_q.delete();
    fork
      begin
        do_req(0, 32'h1000, 4'h0, '0, 1'b0, nc, rd, fm);
        @(posedge clk); #1;
        do_req(0, 32'h1004, 4'h0, '0, 1'b0, nc, rd, fm);
      end
      begin
        do_req(1, 32'h2000, 4'h0, '0, 1'b0, nc1, rd1, fm1);
        @(posedge clk); #1;
        do_req(1, 32'h2004, 4'h0, '0, 1'b0, nc1, rd1, fm1);
      end
    join
    chk("contend_count", grant_q.size(), 4);
    if (grant_q.size() == 4) begin
      chk("contend_g0", grant_q[0], 32'h1000);
      chk("contend_g1", grant_q[1], 32'h2000);
      chk("contend_g2", grant_q[2], 32'h1004);
      chk("contend_g3", grant_q[3], 32'h2004);
    end

    // Protected write at the last word of the window.
    @(posedge clk); #1;
    do_req(1, 32'h8FFC, 4'hF, 32'hCAFE_F00D, 1'b0, nc, rd, fm);
    chk("prot_no_mvalid", fm, 0);
    chk("prot_ready_cycle", nc, 2);
    chk("prot_rdata", rd, FD);
    chk("prot_fault_valid", fault_valid, 1);
    chk("prot_fault_addr", fault_addr, 32'h8FFC);
    chk("prot_fault_write", fault_write, 1);
    // End address is exclusive.
    fix_rd = 32'h0BAD_CAFE;
    do_req(1, 32'h9000, 4'h0, '0, 1'b0, nc, rd, fm);
    chk("edge_pass_mvalid", fm, 2);
    chk("edge_pass_rdata", rd, 32'h0BAD_CAFE);
    // Port 0 is never checked against the window.
    do_req(0, 32'h8000, 4'h0, '0, 1'b0, nc, rd, fm);
    chk("p0_window_mvalid", fm, 2);
    chk("p0_window_fault_addr", fault_addr, 32'h8FFC);

    // Sticky log, then clear and recapture.
    do_req(1, 32'h8000, 4'h0, '0, 1'b0, nc, rd, fm);
    chk("sticky_fault_addr", fault_addr, 32'h8FFC);
    chk("sticky_fault_write", fault_write, 1);
    fault_clr = 1'b1;
    @(posedge clk); #1; fault_clr = 1'b0;
    chk("clr_fault_valid", fault_valid, 0);
    do_req(1, 32'h8004, 4'h0, '0, 1'b1, nc, rd, fm);
    chk("recap_rdata", rd, 32'hDEAD_BEEF);
    chk("recap_fault_valid", fault_valid, 1);
    chk("recap_fault_addr", fault_addr, 32'h8004);
    chk("recap_fault_write", fault_write, 0);

    // Reset while port 1 waits on a slow downstream.
    @(posedge clk); #1;
    fix_lat = 20;
    set_port(1, 1'b1, 32'hA000, 4'h0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_granted", m_bus.valid, 1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_reset_m_valid", m_bus.valid, 0);
    chk("mid_reset_s1_ready", s1_bus.ready, 0);
    chk("mid_reset_fault_valid", fault_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0; fix_lat = 1;
    grant_q.delete();
    fork
      do_req(0, 32'hB000, 4'h0, '0, 1'b0, nc, rd, fm);
      do_req(1, 32'hA000, 4'h0, '0, 1'b0, nc1, rd1, fm1);
    join
    chk("post_reset_count", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      chk("post_reset_first", grant_q[0], 32'hB000);
      chk("post_reset_second", grant_q[1], 32'hA000);
    end

    // Randomized traffic with random latency and occasional fault_clr.
    @(posedge clk); #1;
    fix_lat = -1;
    rand_on = 1;
    fork
      rand_port(0, 80);
      rand_port(1, 80);
    join
    rand_on = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_on) fault_clr = ($urandom_range(0, 15) == 0);
      else if (fault_clr && !rand_on && $time > 0) fault_clr = fault_clr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish before 2000000");
    $fatal(1);
  end

endmodule
